// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops and a bit-serial shifter.
// Valid/ready handshake on both sides; one operation in flight at a time.
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       ALUctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [SHW-1:0]   SHAMT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             ILLEGAL
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SLL,
    OP_SRL,
    OP_ILL
  } op_e;

  state_e state_q, state_d;
  op_e op_dec;

  logic             dir_left_q;
  logic [WIDTH-1:0] sreg_q;
  logic [SHW-1:0]   cnt_q;

  logic             accept;
  logic             is_shift;
  logic             long_shift;
  logic             shift_last;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] sreg_nxt;

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign accept    = IN_VALID && IN_READY;

  always_comb begin
    op_dec = OP_ILL;
    case (ALUctrl)
      4'b0010: op_dec = OP_ADD;
      4'b0100: op_dec = OP_SUB;
      4'b0000: op_dec = OP_AND;
      4'b0001: op_dec = OP_OR;
      4'b1100: op_dec = OP_SLL;
      4'b1010: op_dec = OP_SRL;
      default: op_dec = OP_ILL;
    endcase
  end

  // Zero-amount shifts pass B straight through on the one-cycle path.
  always_comb begin
    alu_res = '0;
    case (op_dec)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_SLL:  alu_res = B;
      OP_SRL:  alu_res = B;
      default: alu_res = '0;
    endcase
  end

  assign is_shift   = (op_dec == OP_SLL) || (op_dec == OP_SRL);
  assign long_shift = is_shift && (SHAMT != '0);
  assign shift_last = (cnt_q == SHW'(1));
  assign sreg_nxt   = dir_left_q ? (sreg_q << 1) : (sreg_q >> 1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = long_shift ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (shift_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RESULT only moves when the final value is known; shifts stay internal.
  always_ff @(posedge clk) begin
    if (rst) begin
      RESULT     <= '0;
      ZERO       <= 1'b0;
      ILLEGAL    <= 1'b0;
      sreg_q     <= '0;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (long_shift) begin
              sreg_q     <= B;
              cnt_q      <= SHAMT;
              dir_left_q <= (op_dec == OP_SLL);
            end else begin
              RESULT  <= alu_res;
              ZERO    <= (alu_res == '0);
              ILLEGAL <= (op_dec == OP_ILL);
            end
          end
        end
        SHIFT: begin
          sreg_q <= sreg_nxt;
          cnt_q  <= cnt_q - SHW'(1);
          if (shift_last) begin
            RESULT  <= sreg_nxt;
            ZERO    <= (sreg_nxt == '0);
            ILLEGAL <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed vector table, hand sequences, random ops.
// Random ops are checked against a plain arithmetic reference model.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [3:0]  ALUctrl = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [4:0]  SHAMT = '0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] RESULT;
  logic        ZERO;
  logic        ILLEGAL;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk),
    .rst(rst),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .ALUctrl(ALUctrl),
    .A(A),
    .B(B),
    .SHAMT(SHAMT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .RESULT(RESULT),
    .ZERO(ZERO),
    .ILLEGAL(ILLEGAL)
  );

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  s;
    logic [31:0] r;
    logic        z;
    logic        il;
    int          lat;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] c, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] s,
                                output logic [31:0] r, output logic il,
                                output int lat);
    il  = 1'b0;
    lat = 1;
    r   = '0;
    case (c)
      4'b0010: r = a + b;
      4'b0100: r = a - b;
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: begin r = b << s; lat = int'(s) + 1; end
      4'b1010: begin r = b >> s; lat = int'(s) + 1; end
      default: begin r = '0; il = 1'b1; end
    endcase
  endfunction

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!IN_READY && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ":in_ready"}, 32'(IN_READY), 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, input logic [31:0] er,
                        input logic ez, input logic ei, input int el);
    int n;
    wait_ready(nm);
    ALUctrl   = c;
    A         = a;
    B         = b;
    SHAMT     = s;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    IN_VALID = 1'b0;
    ALUctrl  = 4'($urandom);
    A        = $urandom;
    B        = $urandom;
    SHAMT    = 5'($urandom);
    n = 1;
    while (!OUT_VALID && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ":latency"}, 32'(n), 32'(el));
    chk({nm, ":result"}, RESULT, er);
    chk({nm, ":zero"}, 32'(ZERO), 32'(ez));
    chk({nm, ":illegal"}, 32'(ILLEGAL), 32'(ei));
    @(negedge clk);
    chk({nm, ":valid_drop"}, 32'(OUT_VALID), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic        saw_valid;
    logic [3:0]  codes[8];
    int          n;

    tbl[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd0,
                32'h0, 1'b1, 1'b0, 1};
    tbl[1]  = '{4'b0100, 32'd5, 32'd7, 5'd0,
                32'hFFFF_FFFE, 1'b0, 1'b0, 1};
    tbl[2]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd3,
                32'hF000_F000, 1'b0, 1'b0, 1};
    tbl[3]  = '{4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5'd9,
                32'hFFFF_FFFF, 1'b0, 1'b0, 1};
    tbl[4]  = '{4'b1100, 32'h1234, 32'h1, 5'd31,
                32'h8000_0000, 1'b0, 1'b0, 32};
    tbl[5]  = '{4'b1100, 32'h0, 32'h1234_5678, 5'd0,
                32'h1234_5678, 1'b0, 1'b0, 1};
    tbl[6]  = '{4'b1010, 32'h0, 32'h8000_0000, 5'd4,
                32'h0800_0000, 1'b0, 1'b0, 5};
    tbl[7]  = '{4'b0111, 32'h1, 32'h2, 5'd0,
                32'h0, 1'b1, 1'b1, 1};
    tbl[8]  = '{4'b0010, 32'd3, 32'd4, 5'd0,
                32'd7, 1'b0, 1'b0, 1};
    tbl[9]  = '{4'b1010, 32'h0, 32'h1, 5'd1,
                32'h0, 1'b1, 1'b0, 2};
    tbl[10] = '{4'b1111, 32'h5, 32'h5, 5'd7,
                32'h0, 1'b1, 1'b1, 1};
    tbl[11] = '{4'b1100, 32'h0, 32'hFFFF_FFFF, 5'd8,
                32'hFFFF_FF00, 1'b0, 1'b0, 9};
    tbl[12] = '{4'b0100, 32'h0, 32'h1, 5'd0,
                32'hFFFF_FFFF, 1'b0, 1'b0, 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset:valid", 32'(OUT_VALID), 32'd0);
    chk("reset:result", RESULT, 32'd0);
    chk("reset:zero", 32'(ZERO), 32'd0);
    chk("reset:illegal", 32'(ILLEGAL), 32'd0);
    chk("reset:in_ready", 32'(IN_READY), 32'd1);

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].c, tbl[i].a, tbl[i].b,
             tbl[i].s, tbl[i].r, tbl[i].z, tbl[i].il, tbl[i].lat);
    end

    // Backpressure on a finished SRL while a new request waits.
    wait_ready("bp");
    ALUctrl   = 4'b1010;
    B         = 32'h8000_0000;
    SHAMT     = 5'd4;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ALUctrl = 4'b0010;
    A       = 32'd1;
    B       = 32'd1;
    n = 1;
    while (!OUT_VALID && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp:latency", 32'(n), 32'd5);
    held = RESULT;
    chk("bp:result", held, 32'h0800_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp:hold_valid", 32'(OUT_VALID), 32'd1);
      chk("bp:hold_result", RESULT, 32'h0800_0000);
      chk("bp:hold_in_ready", 32'(IN_READY), 32'd0);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(negedge clk);
    chk("bp:release_valid", 32'(OUT_VALID), 32'd0);
    chk("bp:release_in_ready", 32'(IN_READY), 32'd1);

    // Reset in the middle of a long SLL must discard it.
    wait_ready("rst_mid");
    ALUctrl  = 4'b1100;
    B        = 32'h1;
    SHAMT    = 5'd20;
    IN_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    IN_VALID = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid:valid", 32'(OUT_VALID), 32'd0);
    chk("rst_mid:result", RESULT, 32'd0);
    chk("rst_mid:zero", 32'(ZERO), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid:in_ready", 32'(IN_READY), 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (OUT_VALID) saw_valid = 1'b1;
    end
    chk("rst_mid:no_valid", 32'(saw_valid), 32'd0);

    // Random ops against the reference model.
    codes = '{4'b0010, 4'b0100, 4'b0000, 4'b0001,
              4'b1100, 4'b1010, 4'b0011, 4'b1111};
    for (int i = 0; i < 60; i++) begin
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  s;
      logic [31:0] r;
      logic        il;
      int          lat;
      c = codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 5) == 0) c = 4'($urandom);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0) b = a;
      s = 5'($urandom);
      model(c, a, b, s, r, il, lat);
      run_op($sformatf("rnd%0d", i), c, a, b, s, r, (r == 32'd0), il, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width.
REQ-002 SHALL have parameter: SHW, 5, shift-amount width (log2 WIDTH).
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: IN_VALID  input  1  operation request valid.
REQ-006 SHALL have port: IN_READY  output  1  block can accept a request.
REQ-007 SHALL have port: ALUctrl  input  4  operation code from ALU control decoder.
REQ-008 SHALL have port: A  input  WIDTH  operand A (rs).
REQ-009 SHALL have port: B  input  WIDTH  operand B (rt / immediate); shift source.
REQ-010 SHALL have port: SHAMT  input  SHW  shift amount.
REQ-011 SHALL have port: OUT_VALID  output  1  result valid.
REQ-012 SHALL have port: OUT_READY  input  1  consumer accepts result.
REQ-013 SHALL have port: RESULT  output  WIDTH  registered result.
REQ-014 SHALL have port: ZERO  output  1  RESULT equals 0.
REQ-015 SHALL have port: ILLEGAL  output  1  unsupported ALUctrl code.

Function
REQ-016 SHALL decode ALUctrl: 0010 ADD, 0100 SUB, 0000 AND, 0001 OR, 1100 SLL, 1010 SRL; all other codes illegal.
REQ-017 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-018 SHALL drive IN_READY = 1 only in IDLE; accept occurs when IN_VALID and IN_READY both 1 at clk edge.
REQ-019 SHALL on accept latch ALUctrl, A, B, SHAMT; later input changes have no effect on the in-flight operation.
REQ-020 SHALL for ADD/SUB/AND/OR: compute A+B, A-B, A&B, A|B modulo 2^WIDTH (carry/borrow discarded), register into RESULT, go IDLE->DONE; OUT_VALID=1 one cycle after accept.
REQ-021 SHALL for illegal code: RESULT=0, ILLEGAL=1, IDLE->DONE, same 1-cycle latency.
REQ-022 SHALL for SLL/SRL with SHAMT=0: RESULT=B, IDLE->DONE, 1-cycle latency.
REQ-023 SHALL for SLL/SRL with SHAMT=N>0: load B into shift register, count=N, go SHIFT; shift one bit per cycle (SLL left, SRL right, zero fill), decrement count; after the Nth shift go DONE; OUT_VALID=1 exactly N+1 cycles after accept.
REQ-024 SHALL hold RESULT, ZERO, ILLEGAL stable while OUT_VALID=1 until OUT_READY=1.
REQ-025 SHALL in DONE with OUT_READY=1: drop OUT_VALID next cycle, go IDLE; IN_READY=1 that next cycle (no same-cycle accept in DONE).
REQ-026 SHALL in DONE with OUT_READY=0: remain in DONE indefinitely.
REQ-027 SHALL compute ZERO and clear ILLEGAL together with RESULT for legal codes; ZERO=1 for illegal-code result.
REQ-028 SHALL ignore IN_VALID outside IDLE and OUT_READY outside DONE.
REQ-029 SHALL leave RESULT unchanged during SHIFT (intermediate values not visible on RESULT).

Reset
REQ-030 SHALL on rst=1 at clk edge: state IDLE, OUT_VALID=0, RESULT=0, ZERO=0, ILLEGAL=0, shift count=0.
REQ-031 SHALL give rst priority over every other event, including accept, SHIFT progress and output handshake.
REQ-032 SHALL abort an in-flight shift or pending result on rst with no OUT_VALID produced.
REQ-033 SHALL drive IN_READY=1 in the first cycle after rst deasserts.

Verification
REQ-034 SHALL cover: ALUctrl=0010, A=0xFFFFFFFF, B=1, OUT_READY=1 -> next cycle OUT_VALID=1, RESULT=0, ZERO=1, ILLEGAL=0.
REQ-035 SHALL cover: ALUctrl=0100, A=5, B=7 -> RESULT=0xFFFFFFFE, ZERO=0, latency 1.
REQ-036 SHALL cover: ALUctrl=1100, B=0x00000001, SHAMT=31 -> OUT_VALID after 32 cycles, RESULT=0x80000000; SHAMT=0 -> RESULT=B after 1 cycle.
REQ-037 SHALL cover: ALUctrl=1010, B=0x80000000, SHAMT=4, OUT_READY=0 for 5 cycles -> RESULT=0x08000000 held stable, IN_READY=0, until OUT_READY=1; then IDLE.
REQ-038 SHALL cover: ALUctrl=0111 -> RESULT=0, ILLEGAL=1, ZERO=1; following legal op clears ILLEGAL.
REQ-039 SHALL cover: rst asserted mid-SLL (SHAMT=20, cycle 10) -> next cycle IDLE, OUT_VALID=0, RESULT=0, IN_READY=1 after rst drops.
